instr_mem_responder: RTL and testbench
======================================

// Module: instr_mem_responder
// PURPOSE
//  Memory-side responder for the cache controller's single-word fetch interface (mem_req_*).
//  Holds a word-addressed instruction store, accepts one request at a time and returns one
//  32-bit word after a programmable latency with a one-cycle ready pulse. Optional LFSR stalls.
//  Sits beside the controller in benches and the FPGA top; preloaded through a write port.
// PARAMETERS
//  MEM_WORDS   1024          words in backing store (power of 2)
//  BASE_ADDR   32'h0000_0000 byte address mapped to word 0
//  LATENCY     2             cycles from request acceptance to ready (>=1)
//  RAND_STALL  0             1: add 0..3 extra cycles per request from LFSR[1:0]
//  LFSR_SEED   16'hACE1      LFSR reset value (nonzero)
//  OOR_DATA    32'h0000_0013 word returned for out-of-range address (RV32 NOP)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  mem_req_valid  in   1   controller request
//  mem_req_ready  out  1   one-cycle response strobe; mem_req_rdata valid this cycle only
//  mem_req_addr   in   32  byte address of requested word
//  mem_req_rdata  out  32  response data; 0 when mem_req_ready=0
//  load_en        in   1   preload write strobe
//  load_addr      in   32  preload byte address (same map as mem_req_addr)
//  load_data      in   32  preload word
//  busy           out  1   state != IDLE
//  oor_error      out  1   sticky: a request or load hit an out-of-range address
//  proto_error    out  1   sticky: handshake violation (see below)
//  req_count      out  32  completed responses, wraps at 2^32
// BEHAVIOUR
//  Reset: state=IDLE, mem_req_ready=0, mem_req_rdata=0, busy=0, oor_error=0, proto_error=0,
//   req_count=0, LFSR=LFSR_SEED. Store contents not reset.
//  Index = (addr-BASE_ADDR)>>2; out of range if addr<BASE_ADDR or index>=MEM_WORDS.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: valid=1 at edge E0 -> latch addr, cnt=LATENCY-1+(RAND_STALL?LFSR[1:0]:0), LFSR steps
//    once, goto WAIT. Latch misaligned addr (addr[1:0]!=0) as word-aligned-down; set proto_error.
//   WAIT: cnt==0 at edge -> goto RESP, register data (store[idx] or OOR_DATA, set oor_error if
//    OOR); else cnt--. Thus ready is high in cycle starting at edge E0+LATENCY(+stall).
//   RESP: mem_req_ready=1 for exactly one cycle; next edge -> IDLE, req_count++, rdata->0.
//    Valid is still 1 during RESP (controller drops it one edge later); IDLE is entered
//    without re-sampling it, so no double response. Earliest next accept: 2 edges after RESP.
//  Violations (set proto_error, sticky until reset):
//   valid=0 during WAIT -> abort to IDLE, no response, req_count unchanged.
//   mem_req_addr != latched addr during WAIT/RESP -> response still uses latched addr.
//  Loads: performed any state; OOR load is dropped and sets oor_error. Load to the word being
//   read on the WAIT->RESP edge: response carries OLD data (read-before-write); earlier loads
//   are visible.
//  reset mid-request: immediate IDLE, ready=0 next cycle, pending response discarded.
// STRUCTURE
//  Package instr_mem_pkg: state enum (IDLE/WAIT/RESP), RV32_NOP constant, idx/oor function.
//  Sub-module lfsr16 (x^16+x^14+x^13+x^11+1, load seed on reset, step on enable).
//  Store: single array, 1 write port (load), 1 registered read port.
// TESTING
//  Preload word@0x10=0xDEADBEEF, LATENCY=2; valid at E0 addr 0x10 -> ready+rdata=0xDEADBEEF
//   only in cycle after E0+2 edges, rdata=0 otherwise, req_count=1.
//  Controller-style 4-word line fetch 0x40..0x4C -> 4 single-cycle ready pulses in order,
//   no duplicate pulse, req_count=4, proto_error=0.
//  addr = BASE_ADDR+4*MEM_WORDS -> rdata=0x00000013, oor_error=1, proto_error=0.
//  Drop valid during WAIT -> no ready, proto_error=1, busy=0 next cycle; reset -> all flags 0.
//  RAND_STALL=1, seed 0xACE1, 100 requests -> latencies in [LATENCY,LATENCY+3], match ref
//   LFSR model; reset asserted in WAIT -> ready never pulses, next request served normally.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// ============================================================================
// Module : instr_mem_pkg
// Brief  : Shared types, constants and address helpers for instr_mem_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] RV32_NOP = 32'h0000_0013;

   // Word offset of a byte address relative to the window base.
   function automatic logic [31:0] word_off(input logic [31:0] addr,
                                            input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

   // Out of range when below the base or past the last word of the store.
   function automatic logic is_oor(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] off,
                                   input int unsigned words);
      return (addr < base) || (off >= words);
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_responder_if.sv
// ============================================================================
// Module : instr_mem_responder_if
// Brief  : Single-word fetch handshake between cache controller and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_mem_responder_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_rdata;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      input  mem_req_ready,
      input  mem_req_rdata
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      output mem_req_ready,
      output mem_req_rdata
   );
endinterface

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// Module : lfsr16
// Brief  : 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, steps when enabled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_en,
   output logic [1:0]      o_low
);

   logic [15:0] r_lfsr;
   logic        w_fb;

   // Right-shifting form: taps 16/14/13/11 land on bits 0/2/3/5.
   assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign o_low = r_lfsr[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= SEED;
      end else if (i_en) begin
         r_lfsr <= {w_fb, r_lfsr[15:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// ============================================================================
// Module : instr_mem_responder
// Brief  : Word-addressed instruction store answering one fetch at a time
//          after a programmable (optionally randomised) latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_responder
   import instr_mem_pkg::*;
#(
   parameter int          MEM_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          LATENCY    = 2,
   parameter int          RAND_STALL = 0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter logic [31:0] OOR_DATA   = RV32_NOP
) (
   input  wire logic              clk,
   input  wire logic              reset,
   instr_mem_responder_if.slave   bus,
   input  wire logic              load_en,
   input  wire logic [31:0]       load_addr,
   input  wire logic [31:0]       load_data,
   output logic                   busy,
   output logic                   oor_error,
   output logic                   proto_error,
   output logic [31:0]            req_count
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:0]        r_addr;
   logic [IDX_W-1:0]   r_idx;
   logic               r_oor;
   logic [31:0]        r_cnt;
   logic [31:0]        r_rdata;
   logic [31:0]        r_req_count;
   logic               r_oor_err;
   logic               r_proto_err;
   logic [31:0]        r_mem [MEM_WORDS];

   logic               w_accept;
   logic               w_fire;
   logic               w_abort;
   logic               w_done;
   logic               w_mismatch;
   logic [1:0]         w_lfsr_lo;
   logic [31:0]        w_stall;
   logic [31:0]        w_acc_off;
   logic               w_acc_oor;
   logic [31:0]        w_load_off;
   logic               w_load_oor;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (reset),
      .i_en  (w_accept),
      .o_low (w_lfsr_lo)
   );

   assign w_stall    = (RAND_STALL != 0) ? {30'd0, w_lfsr_lo} : 32'd0;
   assign w_acc_off  = word_off(bus.mem_req_addr, BASE_ADDR);
   assign w_acc_oor  = is_oor(bus.mem_req_addr, BASE_ADDR, w_acc_off, MEM_WORDS);
   assign w_load_off = word_off(load_addr, BASE_ADDR);
   assign w_load_oor = is_oor(load_addr, BASE_ADDR, w_load_off, MEM_WORDS);

   // The controller must hold the address it was accepted with until it sees ready.
   assign w_mismatch = ((r_state == WAIT) || (r_state == RESP)) &&
                       (bus.mem_req_addr != r_addr);

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fire      = 1'b0;
      w_abort     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.mem_req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (!bus.mem_req_valid) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end else if (r_cnt == 32'd0) begin
               w_fire      = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            // Valid is still high here; IDLE must not re-sample it this edge.
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= 32'd0;
         r_idx       <= '0;
         r_oor       <= 1'b0;
         r_cnt       <= 32'd0;
         r_rdata     <= 32'd0;
         r_req_count <= 32'd0;
         r_oor_err   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr <= {bus.mem_req_addr[31:2], 2'b00};
            r_idx  <= w_acc_off[IDX_W-1:0];
            r_oor  <= w_acc_oor;
            r_cnt  <= 32'(LATENCY - 1) + w_stall;
         end else if ((r_state == WAIT) && (r_cnt != 32'd0)) begin
            r_cnt <= r_cnt - 32'd1;
         end
         // Read happens in the same edge as a possible load: old word wins.
         if (w_fire) begin
            r_rdata <= r_oor ? OOR_DATA : r_mem[r_idx];
         end else if (w_done) begin
            r_rdata <= 32'd0;
         end
         if (w_done) begin
            r_req_count <= r_req_count + 32'd1;
         end
         if ((w_fire && r_oor) || (load_en && w_load_oor)) begin
            r_oor_err <= 1'b1;
         end
         if ((w_accept && (bus.mem_req_addr[1:0] != 2'b00)) || w_abort || w_mismatch) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_en && !w_load_oor) begin
         r_mem[w_load_off[IDX_W-1:0]] <= load_data;
      end
   end

   assign bus.mem_req_ready = (r_state == RESP);
   assign bus.mem_req_rdata = r_rdata;
   assign busy              = (r_state != IDLE);
   assign oor_error         = r_oor_err;
   assign proto_error       = r_proto_err;
   assign req_count         = r_req_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
// ============================================================================
// Module : tb_instr_mem_responder
// Brief  : Directed plus randomised bench for instr_mem_responder (fixed and
//          LFSR-stalled latency instances) against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_responder;

   localparam int          LAT  = 2;
   localparam int          MW   = 1024;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        busy    [2];
   logic        oor_e   [2];
   logic        proto_e [2];
   logic [31:0] cnt     [2];

   always #5 clk = ~clk;

   instr_mem_responder_if if0 ();
   instr_mem_responder_if if1 ();

   instr_mem_responder #(
      .MEM_WORDS(MW), .BASE_ADDR(32'h0), .LATENCY(LAT), .RAND_STALL(0),
      .LFSR_SEED(SEED), .OOR_DATA(32'h0000_0013)
   ) dut0 (
      .clk(clk), .reset(reset), .bus(if0),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy[0]), .oor_error(oor_e[0]), .proto_error(proto_e[0]), .req_count(cnt[0])
   );

   instr_mem_responder #(
      .MEM_WORDS(MW), .BASE_ADDR(32'h0), .LATENCY(LAT), .RAND_STALL(1),
      .LFSR_SEED(SEED), .OOR_DATA(32'h0000_0013)
   ) dut1 (
      .clk(clk), .reset(reset), .bus(if1),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy[1]), .oor_error(oor_e[1]), .proto_error(proto_e[1]), .req_count(cnt[1])
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ref_mem [MW];
   int          ref_lfsr;
   int          ref_cnt [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic get_rdy(input int s);
      return (s == 0) ? if0.mem_req_ready : if1.mem_req_ready;
   endfunction

   function automatic logic [31:0] get_rdata(input int s);
      return (s == 0) ? if0.mem_req_rdata : if1.mem_req_rdata;
   endfunction

   task automatic drive(input int s, input logic v, input logic [31:0] a);
      if (s == 0) begin
         if0.mem_req_valid = v;
         if0.mem_req_addr  = a;
      end else begin
         if1.mem_req_valid = v;
         if1.mem_req_addr  = a;
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (a >= 32'(4 * MW)) return 32'h0000_0013;
      return ref_mem[a[11:2]];
   endfunction

   function automatic int lfsr_step(input int x);
      return ((x >> 1) | (((x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1) << 15)) & 32'hFFFF;
   endfunction

   task automatic do_load(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(posedge clk); #1;
      load_en = 1'b0;
      if (a < 32'(4 * MW)) ref_mem[a[11:2]] = d;
   endtask

   // One controller-style fetch; optional load to the same word on the response edge.
   task automatic do_req(input int s, input logic [31:0] a, input int exp_lat,
                         input string tag, input bit rbw, input logic [31:0] rbw_d);
      logic [31:0] exp_d;
      bit          seen;
      exp_d = ref_read(a);
      seen  = 1'b0;
      drive(s, 1'b1, a);
      @(posedge clk); #1;
      for (int k = 1; k <= exp_lat + 6 && !seen; k++) begin
         if (rbw && k == exp_lat) begin
            load_en   = 1'b1;
            load_addr = {a[31:2], 2'b00};
            load_data = rbw_d;
         end
         @(posedge clk); #1;
         load_en = 1'b0;
         if (get_rdy(s)) begin
            seen = 1'b1;
            chk({tag, " latency"}, 32'(k), 32'(exp_lat));
            chk({tag, " data"}, get_rdata(s), exp_d);
         end else begin
            chk({tag, " rdata while not ready"}, get_rdata(s), 32'd0);
         end
      end
      chk({tag, " ready seen"}, 32'(seen), 32'd1);
      if (rbw) ref_mem[a[11:2]] = rbw_d;
      ref_cnt[s]++;
      @(posedge clk); #1;
      chk({tag, " single pulse"}, 32'(get_rdy(s)), 32'd0);
      chk({tag, " rdata cleared"}, get_rdata(s), 32'd0);
      drive(s, 1'b0, a);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset      = 1'b0;
      ref_lfsr   = int'(SEED);
      ref_cnt[0] = 0;
      ref_cnt[1] = 0;
   endtask

   initial begin
      int lat;
      logic [31:0] a;
      reset   = 1'b1;
      load_en = 1'b0;
      load_addr = 32'd0;
      load_data = 32'd0;
      drive(0, 1'b0, 32'd0);
      drive(1, 1'b0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("reset ready", 32'(get_rdy(s)), 32'd0);
         chk("reset rdata", get_rdata(s), 32'd0);
         chk("reset busy", 32'(busy[s]), 32'd0);
         chk("reset oor", 32'(oor_e[s]), 32'd0);
         chk("reset proto", 32'(proto_e[s]), 32'd0);
         chk("reset count", cnt[s], 32'd0);
      end
      reset      = 1'b0;
      ref_lfsr   = int'(SEED);
      ref_cnt[0] = 0;
      ref_cnt[1] = 0;

      do_load(32'h10, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) do_load(32'h40 + 32'(4 * i), $urandom);

      do_req(0, 32'h10, LAT, "basic", 1'b0, 32'd0);
      chk("basic count", cnt[0], 32'(ref_cnt[0]));

      for (int i = 0; i < 4; i++) do_req(0, 32'h40 + 32'(4 * i), LAT, "line", 1'b0, 32'd0);
      chk("line count", cnt[0], 32'(ref_cnt[0]));
      chk("line proto", 32'(proto_e[0]), 32'd0);

      do_req(0, 32'(4 * MW), LAT, "oor", 1'b0, 32'd0);
      chk("oor flag", 32'(oor_e[0]), 32'd1);
      chk("oor proto", 32'(proto_e[0]), 32'd0);

      // Valid withdrawn while waiting: request aborted.
      drive(0, 1'b1, 32'h10);
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h10);
      @(posedge clk); #1;
      chk("abort busy", 32'(busy[0]), 32'd0);
      chk("abort proto", 32'(proto_e[0]), 32'd1);
      chk("abort count", cnt[0], 32'(ref_cnt[0]));
      repeat (3) begin
         chk("abort ready", 32'(get_rdy(0)), 32'd0);
         @(posedge clk); #1;
      end

      pulse_reset();
      chk("post-reset oor", 32'(oor_e[0]), 32'd0);
      chk("post-reset proto", 32'(proto_e[0]), 32'd0);
      chk("post-reset count", cnt[0], 32'd0);

      do_req(0, 32'h11, LAT, "misalign", 1'b0, 32'd0);
      chk("misalign proto", 32'(proto_e[0]), 32'd1);

      do_req(0, 32'h40, LAT, "rbw", 1'b1, 32'hCAFE_F00D);
      do_req(0, 32'h40, LAT, "after rbw", 1'b0, 32'd0);
      chk("rbw count", cnt[0], 32'(ref_cnt[0]));

      // Randomised stall instance.
      pulse_reset();
      for (int i = 0; i < 64; i++) do_load(32'(4 * i), $urandom);
      for (int n = 0; n < 100; n++) begin
         a        = 32'(4 * $urandom_range(0, 63));
         lat      = LAT + (ref_lfsr & 3);
         ref_lfsr = lfsr_step(ref_lfsr);
         do_req(1, a, lat, "stall", 1'b0, 32'd0);
      end
      chk("stall count", cnt[1], 32'(ref_cnt[1]));
      chk("stall proto", 32'(proto_e[1]), 32'd0);

      // Reset while a request is in flight.
      drive(1, 1'b1, 32'h8);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(1, 1'b0, 32'h8);
      @(posedge clk); #1;
      reset      = 1'b0;
      ref_lfsr   = int'(SEED);
      ref_cnt[1] = 0;
      repeat (6) begin
         chk("reset-in-wait ready", 32'(get_rdy(1)), 32'd0);
         @(posedge clk); #1;
      end
      chk("reset-in-wait count", cnt[1], 32'd0);
      lat      = LAT + (ref_lfsr & 3);
      ref_lfsr = lfsr_step(ref_lfsr);
      do_req(1, 32'h8, lat, "after reset", 1'b0, 32'd0);
      chk("after reset count", cnt[1], 32'(ref_cnt[1]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
